uart_phy: RTL
=============

Name: uart_phy

Overview:
- Serial PHY sitting directly below the memory-mapped UART lite register block.
- TX path: consumes the byte strobe (tx_data/tx_valid, answered with tx_ready) and serialises it onto uart_txd as 8N1.
- RX path: deserialises uart_rxd and hands each received byte upstream as a one-cycle rx_ready pulse, which pushes the byte into the upstream receive FIFO.
- Fixed bit timing from a clock-divide parameter; no runtime baud configuration.

Parameters:
- CLK_DIV, 434, clock cycles per bit (50 MHz / 115200); must be >= 4.
- SYNC_STAGES, 2, flip-flop stages synchronising uart_rxd; must be >= 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- tx_data  input  8  byte to transmit, sampled when tx_valid && tx_ready.
- tx_valid  input  1  single-cycle transmit strobe from upstream.
- tx_ready  output  1  registered; 1 = holding register empty, a strobe will be accepted.
- rx_data  output  8  last received byte; valid during the rx_ready pulse, held afterwards.
- rx_ready  output  1  one-cycle pulse per good received byte.
- rx_ferr  output  1  one-cycle pulse on framing error (stop bit sampled 0).
- uart_txd  output  1  serial out, idle high.
- uart_rxd  input  1  serial in, asynchronous.

Behaviour:
- Reset values: uart_txd=1, tx_ready=1, rx_data=0, rx_ready=0, rx_ferr=0. Both FSMs go to IDLE and all counters clear. Reset mid-frame aborts the frame immediately; uart_txd returns high asynchronously.
- TX holding register:
  - On tx_valid && tx_ready at edge E0: capture tx_data, set hold_full, tx_ready=0 from E0.
  - tx_valid while tx_ready=0: the byte is dropped silently (upstream has no retry).
- TX FSM states: IDLE, START, DATA, STOP (plus PARITY, see Optional Feature).
  - IDLE with hold_full at edge E1: load shifter, clear hold_full (tx_ready=1 from E1), enter START, uart_txd=0 from E1.
  - Each bit lasts exactly CLK_DIV cycles, timed by a bit counter.
  - DATA sends 8 bits LSB first, tracked by a 3-bit index.
  - STOP drives 1 for CLK_DIV cycles. At the end of STOP: if hold_full, go directly to START with no idle gap; otherwise go to IDLE.
  - Frame length is 10*CLK_DIV cycles.
- RX synchroniser: uart_rxd passes through SYNC_STAGES flops, reset value 1. All RX decisions use the synchronised signal.
- RX FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: a synchronised 0 enters START and clears the counter.
  - START: at CLK_DIV/2 (integer divide), re-sample. If 1, treat as a glitch and return to IDLE with no output. If 0, enter DATA.
  - DATA: sample every CLK_DIV cycles thereafter (bit centre), shifting LSB first; after 8 samples enter STOP.
  - STOP, sample after CLK_DIV cycles:
    - 1: rx_data <= shifter and rx_ready=1 for one cycle; return to IDLE.
    - 0: rx_ferr=1 for one cycle, rx_data unchanged, no rx_ready; enter WAIT_HIGH.
  - WAIT_HIGH: stay until the synchronised line is 1, then go to IDLE. A break therefore yields exactly one rx_ferr.
- rx_ready and rx_ferr are never both high in the same cycle. TX and RX are fully independent (loopback allowed).

Optional Feature:
- Macro UART_PHY_PARITY_EN.
- Defined:
  - TX inserts an even-parity bit (XOR of the 8 data bits) in a PARITY state between DATA and STOP; frame = 11*CLK_DIV.
  - RX samples a parity bit before STOP. On mismatch, with a valid stop bit: output rx_perr (extra 1-bit output port) pulses for one cycle, no rx_ready, rx_data unchanged.
  - Framing error takes priority over parity error.
- Undefined: no PARITY state, no rx_perr port, 8N1 only.

Test Plan:
- Reset, CLK_DIV=16: assert rst mid-TX-frame -> uart_txd=1, tx_ready=1, rx_ready=0 immediately; after release, no spurious activity for 200 cycles.
- TX 0x55, CLK_DIV=16: strobe at E0 -> tx_ready=0 at E0; uart_txd=0 from E1 for 16 cycles, then 1,0,1,0,1,0,1,0 at 16 cycles each, then stop 1; tx_ready=1 from E1; frame 160 cycles.
- Back-to-back TX 0xA5 then 0x3C (second strobe once tx_ready=1) -> second start bit begins the cycle after the first stop bit ends; a third strobe while tx_ready=0 is dropped and never appears on the line.
- RX 0xC3 driven at CLK_DIV=16 -> exactly one rx_ready pulse with rx_data=0xC3; rx_data still 0xC3 100 cycles later.
- RX line low for 3 cycles only -> no rx_ready, no rx_ferr. Frame 0x81 with stop bit 0 held low 40 cycles -> one rx_ferr pulse, no rx_ready; a following valid 0x7E is received correctly.
- With UART_PHY_PARITY_EN: TX 0x03 -> parity bit 0, frame 176 cycles. RX 0x07 with parity bit 0 -> one rx_perr pulse, no rx_ready. RX 0x07 with parity 1 -> rx_ready, rx_data=0x07.

Source files
------------

// File: rtl/uart_phy.sv
`default_nettype none
// ============================================================================
// Module      : uart_phy
// Description : Serial PHY beneath the UART lite register block. The TX path
//               takes a byte strobe into a one-entry holding register and
//               serialises it onto uart_txd as 8N1. The RX path synchronises
//               uart_rxd, deserialises 8N1 frames and emits one-cycle
//               rx_ready / rx_ferr pulses.
//               Bit timing is fixed at CLK_DIV clocks per bit.
// Optional    : `define UART_PHY_PARITY_EN adds an even-parity bit to both
//               directions and the rx_perr output port.
// Ports       : clk       system clock, rising edge
//               rst       asynchronous active-high reset
//               tx_data   byte to send, taken when tx_valid && tx_ready
//               tx_valid  single-cycle transmit strobe
//               tx_ready  1 = holding register empty
//               rx_data   last good received byte (held)
//               rx_ready  one-cycle pulse per good byte
//               rx_ferr   one-cycle pulse on framing error
//               rx_perr   one-cycle pulse on parity error (parity build only)
//               uart_txd  serial out, idle high
//               uart_rxd  serial in, asynchronous
// Revision    : 1.0 - initial release
// ============================================================================
module uart_phy #(
   parameter int CLK_DIV     = 434,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_ready,
   output logic       rx_ferr,
`ifdef UART_PHY_PARITY_EN
   output logic       rx_perr,
`endif
   output logic       uart_txd,
   input  logic       uart_rxd
);

   localparam int CNT_W = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);

   generate
      if (CLK_DIV < 4) begin : g_bad_clk_div
         $error("uart_phy: CLK_DIV must be >= 4");
      end
      if (SYNC_STAGES < 2) begin : g_bad_sync_stages
         $error("uart_phy: SYNC_STAGES must be >= 2");
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Transmitter
   // ------------------------------------------------------------------------
   localparam logic [2:0] TX_IDLE   = 3'd0;
   localparam logic [2:0] TX_START  = 3'd1;
   localparam logic [2:0] TX_DATA   = 3'd2;
   localparam logic [2:0] TX_STOP   = 3'd3;
`ifdef UART_PHY_PARITY_EN
   localparam logic [2:0] TX_PARITY = 3'd4;
`endif

   logic [2:0]       tx_state;
   logic [CNT_W-1:0] tx_cnt;
   logic [2:0]       tx_idx;
   logic [7:0]       tx_hold;
   logic [7:0]       tx_shift;
`ifdef UART_PHY_PARITY_EN
   logic             tx_par;
`endif
   logic             tx_bit_end;
   logic             tx_load;

   assign tx_bit_end = (tx_state != TX_IDLE) && (tx_cnt == BIT_LAST);
   // tx_ready low means the holding register is full. A pending byte is
   // launched from IDLE, or straight out of the end of STOP with no gap.
   assign tx_load    = !tx_ready &&
                       ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_bit_end));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= '0;
         tx_idx   <= '0;
         tx_hold  <= '0;
         tx_shift <= '0;
         tx_ready <= 1'b1;
         uart_txd <= 1'b1;
`ifdef UART_PHY_PARITY_EN
         tx_par   <= 1'b0;
`endif
      end else begin
         // Strobes arriving while the holding register is full are dropped.
         if (tx_valid && tx_ready) begin
            tx_hold  <= tx_data;
            tx_ready <= 1'b0;
         end

         if (tx_state != TX_IDLE) begin
            tx_cnt <= tx_bit_end ? '0 : tx_cnt + 1'b1;
         end

         if (tx_bit_end) begin
            case (tx_state)
               TX_START: begin
                  tx_state <= TX_DATA;
                  tx_idx   <= '0;
                  uart_txd <= tx_shift[0];
               end
               TX_DATA: begin
                  if (tx_idx == 3'd7) begin
`ifdef UART_PHY_PARITY_EN
                     tx_state <= TX_PARITY;
                     uart_txd <= tx_par;
`else
                     tx_state <= TX_STOP;
                     uart_txd <= 1'b1;
`endif
                  end else begin
                     tx_idx   <= tx_idx + 1'b1;
                     tx_shift <= {1'b0, tx_shift[7:1]};
                     uart_txd <= tx_shift[1];
                  end
               end
`ifdef UART_PHY_PARITY_EN
               TX_PARITY: begin
                  tx_state <= TX_STOP;
                  uart_txd <= 1'b1;
               end
`endif
               TX_STOP: begin
                  tx_state <= TX_IDLE;
                  uart_txd <= 1'b1;
               end
               default: begin
                  tx_state <= TX_IDLE;
                  uart_txd <= 1'b1;
               end
            endcase
         end

         // Launch overrides the STOP->IDLE transition above.
         if (tx_load) begin
            tx_shift <= tx_hold;
            tx_ready <= 1'b1;
            tx_state <= TX_START;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            uart_txd <= 1'b0;
`ifdef UART_PHY_PARITY_EN
            tx_par   <= ^tx_hold;
`endif
         end
      end
   end

   // ------------------------------------------------------------------------
   // Receiver
   // ------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] rx_sync;
   logic                   rxd_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_sync <= '1;
      end else begin
         rx_sync <= {rx_sync[SYNC_STAGES-2:0], uart_rxd};
      end
   end

   assign rxd_s = rx_sync[SYNC_STAGES-1];

   localparam logic [2:0] RX_IDLE      = 3'd0;
   localparam logic [2:0] RX_START     = 3'd1;
   localparam logic [2:0] RX_DATA      = 3'd2;
   localparam logic [2:0] RX_STOP      = 3'd3;
   localparam logic [2:0] RX_WAIT_HIGH = 3'd4;
`ifdef UART_PHY_PARITY_EN
   localparam logic [2:0] RX_PARITY    = 3'd5;
`endif

   logic [2:0]       rx_state;
   logic [CNT_W-1:0] rx_cnt;
   logic [2:0]       rx_idx;
   logic [7:0]       rx_shift;
`ifdef UART_PHY_PARITY_EN
   logic             rx_par_bit;
`endif
   logic             rx_bit_end;

   assign rx_bit_end = (rx_cnt == BIT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state   <= RX_IDLE;
         rx_cnt     <= '0;
         rx_idx     <= '0;
         rx_shift   <= '0;
         rx_data    <= '0;
         rx_ready   <= 1'b0;
         rx_ferr    <= 1'b0;
`ifdef UART_PHY_PARITY_EN
         rx_par_bit <= 1'b0;
         rx_perr    <= 1'b0;
`endif
      end else begin
         rx_ready <= 1'b0;
         rx_ferr  <= 1'b0;
`ifdef UART_PHY_PARITY_EN
         rx_perr  <= 1'b0;
`endif
         case (rx_state)
            RX_IDLE: begin
               rx_cnt <= '0;
               if (!rxd_s) begin
                  rx_state <= RX_START;
               end
            end
            // Half a bit into the start bit: a line back at 1 was a glitch.
            RX_START: begin
               if (rx_cnt == HALF_LAST) begin
                  rx_cnt   <= '0;
                  rx_idx   <= '0;
                  rx_state <= rxd_s ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (rx_bit_end) begin
                  rx_cnt   <= '0;
                  rx_shift <= {rxd_s, rx_shift[7:1]};
                  if (rx_idx == 3'd7) begin
`ifdef UART_PHY_PARITY_EN
                     rx_state <= RX_PARITY;
`else
                     rx_state <= RX_STOP;
`endif
                  end else begin
                     rx_idx <= rx_idx + 1'b1;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
`ifdef UART_PHY_PARITY_EN
            RX_PARITY: begin
               if (rx_bit_end) begin
                  rx_cnt     <= '0;
                  rx_par_bit <= rxd_s;
                  rx_state   <= RX_STOP;
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
`endif
            RX_STOP: begin
               if (rx_bit_end) begin
                  rx_cnt <= '0;
                  if (rxd_s) begin
                     rx_state <= RX_IDLE;
`ifdef UART_PHY_PARITY_EN
                     if (rx_par_bit != ^rx_shift) begin
                        rx_perr <= 1'b1;
                     end else begin
                        rx_data  <= rx_shift;
                        rx_ready <= 1'b1;
                     end
`else
                     rx_data  <= rx_shift;
                     rx_ready <= 1'b1;
`endif
                  end else begin
                     // Framing error wins over any parity result.
                     rx_ferr  <= 1'b1;
                     rx_state <= RX_WAIT_HIGH;
                  end
               end else begin
                  rx_cnt <= rx_cnt + 1'b1;
               end
            end
            // Hold off until the line idles so a break gives one rx_ferr only.
            RX_WAIT_HIGH: begin
               rx_cnt <= '0;
               if (rxd_s) begin
                  rx_state <= RX_IDLE;
               end
            end
            default: begin
               rx_state <= RX_IDLE;
               rx_cnt   <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
